frame_write_feeder: RTL and testbench

- Upstream feeder for the FPGA-to-SDRAM write master.
- Accepts the HPS-side master_ctrl configuration: base, length, go, enable and mode bits.
- Launches one write-master transaction per frame through write_control.
- Moves a 32-bit valid/ready pixel/sample stream into write_user through a local show-ahead FIFO, and reports busy back to the HPS through master_ctrl_control_state.

---
 rtl/frame_write_feeder.sv | 217 +++++++++++++++++++++
 tb/tb_frame_write_feeder.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_feeder.sv
// frame_write_feeder: launches one write-master transaction per frame and streams words into write_user.
// Latency: wm_go one cycle after an accepted go edge; a stream word can reach write_user the cycle after it is accepted.
// Backpressure: wm_buffer_full stalls pops; s_ready drops when the local FIFO is full or the frame's words are all accepted.
//
// Ports:
//   clk, rst_n                          clock and asynchronous active-low reset
//   cfg_base/cfg_length/cfg_go/cfg_en   HPS master_ctrl configuration (byte base, byte length, go level, {rearm, enable})
//   status_busy                         high while a frame is launching, transferring or finishing
//   s_valid/s_data/s_ready              upstream word stream
//   wm_*                                write-master control and write_user buffer interface
//   frame_done/cfg_err/frame_cnt        end-of-frame pulse, sticky bad-config flag, completed frame counter

// sync_fifo: show-ahead synchronous FIFO, head word visible on rd_dat whenever not empty.
// Latency: a written word is visible at the head one cycle after the write.
// Backpressure: writes when full are dropped unless a read happens the same cycle; full/empty are registered.
module sync_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_dat,
   input  logic         rd_en,
   output logic [W-1:0] rd_dat,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_nxt;
   logic          do_wr;
   logic          do_rd;

   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   // Empty FIFO presents zero so the data output is quiet between frames and in reset.
   assign rd_dat = empty ? '0 : mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({do_wr, do_rd})
         2'b10:   count_nxt = count + CNT_ONE;
         2'b01:   count_nxt = count - CNT_ONE;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
         count <= count_nxt;
         full  <= (count_nxt == FULL_CNT);
         empty <= (count_nxt == '0);
      end
   end
endmodule

module frame_write_feeder #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 30
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       cfg_base,
   input  logic [31:0]       cfg_length,
   input  logic              cfg_go,
   input  logic [1:0]        cfg_en,
   output logic              status_busy,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              wm_fixed_location,
   output logic [31:0]       wm_write_base,
   output logic [31:0]       wm_write_length,
   output logic              wm_go,
   input  logic              wm_done,
   output logic              wm_write_buffer,
   output logic [DATA_W-1:0] wm_buffer_data,
   input  logic              wm_buffer_full,
   output logic              frame_done,
   output logic              cfg_err,
   output logic [15:0]       frame_cnt
);
   typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, XFER = 2'd2, FINISH = 2'd3} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   logic             cfg_go_q;
   logic             go_rise;
   logic             cfg_bad;
   logic             fin_ok;
   logic             try_launch;
   logic             launch;
   logic             done_low_seen;
   logic [CNT_W-1:0] total;
   logic [CNT_W-1:0] acc_cnt;
   logic [CNT_W-1:0] push_cnt;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;

   assign wm_fixed_location = 1'b0;

   assign go_rise = cfg_go & ~cfg_go_q;
   assign cfg_bad = (cfg_length == 32'd0) || (cfg_length[1:0] != 2'b00) || (cfg_base[1:0] != 2'b00);

   // Frame end needs the master to have dropped done at least once since launch,
   // otherwise its idle-high done would end the frame immediately.
   assign fin_ok     = (state == FINISH) & wm_done & done_low_seen;
   assign try_launch = ((state == IDLE) & go_rise & cfg_en[0]) | (fin_ok & (cfg_en == 2'b11));
   assign launch     = try_launch & ~cfg_bad;

   // Acceptance uses the registered full flag, so a push never lands on a full FIFO.
   assign s_ready = ((state == LAUNCH) || (state == XFER)) & ~fifo_full & (acc_cnt < total);
   assign push    = s_valid & s_ready;

   assign wm_write_buffer = (state == XFER) & ~fifo_empty & ~wm_buffer_full & (push_cnt < total);
   assign pop             = wm_write_buffer;

   sync_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (push),
      .wr_dat (s_data),
      .rd_en  (pop),
      .rd_dat (wm_buffer_data),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         cfg_go_q        <= 1'b0;
         wm_write_base   <= '0;
         wm_write_length <= '0;
         wm_go           <= 1'b0;
         status_busy     <= 1'b0;
         frame_done      <= 1'b0;
         cfg_err         <= 1'b0;
         frame_cnt       <= '0;
         total           <= '0;
         acc_cnt         <= '0;
         push_cnt        <= '0;
         done_low_seen   <= 1'b0;
      end else begin
         cfg_go_q   <= cfg_go;
         wm_go      <= 1'b0;
         frame_done <= 1'b0;
         if (push) acc_cnt  <= acc_cnt + CNT_ONE;
         if (pop)  push_cnt <= push_cnt + CNT_ONE;

         case (state)
            IDLE: ;
            LAUNCH: begin
               done_low_seen <= 1'b0;
               state         <= XFER;
            end
            XFER: begin
               if (!wm_done) done_low_seen <= 1'b1;
               if (pop && ((push_cnt + CNT_ONE) == total)) state <= FINISH;
            end
            FINISH: begin
               if (!wm_done) done_low_seen <= 1'b1;
               if (fin_ok) begin
                  frame_done  <= 1'b1;
                  frame_cnt   <= frame_cnt + 16'd1;
                  state       <= IDLE;
                  status_busy <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         // Launch from IDLE or a continuous re-arm from FINISH; overrides the IDLE move above.
         if (launch) begin
            wm_write_base   <= cfg_base;
            wm_write_length <= cfg_length;
            total           <= cfg_length[CNT_W+1:2];
            acc_cnt         <= '0;
            push_cnt        <= '0;
            cfg_err         <= 1'b0;
            wm_go           <= 1'b1;
            status_busy     <= 1'b1;
            state           <= LAUNCH;
         end else if (try_launch) begin
            cfg_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_frame_write_feeder.sv
// tb_frame_write_feeder: randomized self-checking bench for frame_write_feeder.
// Latency: inputs driven at the falling edge, outputs sampled 1 ns later.
// Backpressure: a behavioural write-master model drives wm_done and wm_buffer_full.
module tb_frame_write_feeder;
   localparam int DATA_W     = 32;
   localparam int FIFO_DEPTH = 16;
   localparam int CNT_W      = 30;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [31:0]       cfg_base = '0;
   logic [31:0]       cfg_length = '0;
   logic              cfg_go = 1'b0;
   logic [1:0]        cfg_en = 2'b00;
   logic              status_busy;
   logic              s_valid = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_ready;
   logic              wm_fixed_location;
   logic [31:0]       wm_write_base;
   logic [31:0]       wm_write_length;
   logic              wm_go;
   logic              wm_done = 1'b1;
   logic              wm_write_buffer;
   logic [DATA_W-1:0] wm_buffer_data;
   logic              wm_buffer_full = 1'b0;
   logic              frame_done;
   logic              cfg_err;
   logic [15:0]       frame_cnt;

   always #5 clk = ~clk;

   frame_write_feeder #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cfg_base          (cfg_base),
      .cfg_length        (cfg_length),
      .cfg_go            (cfg_go),
      .cfg_en            (cfg_en),
      .status_busy       (status_busy),
      .s_valid           (s_valid),
      .s_data            (s_data),
      .s_ready           (s_ready),
      .wm_fixed_location (wm_fixed_location),
      .wm_write_base     (wm_write_base),
      .wm_write_length   (wm_write_length),
      .wm_go             (wm_go),
      .wm_done           (wm_done),
      .wm_write_buffer   (wm_write_buffer),
      .wm_buffer_data    (wm_buffer_data),
      .wm_buffer_full    (wm_buffer_full),
      .frame_done        (frame_done),
      .cfg_err           (cfg_err),
      .frame_cnt         (frame_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model state: accepted words in order, per-frame word bookkeeping, master model.
   logic [31:0] exp_q[$];
   logic [31:0] next_data = '0;
   logic [31:0] first_w = '0;
   logic [31:0] last_w = '0;
   int src_mode = 0;     // 0 idle, 1 always valid, 2 random valid
   int full_mode = 0;    // 0 never, 1 random, 2 20-cycle toggle, 3 held high
   int go_cnt = 0, last_go_cyc = -1, fd_cnt = 0, last_fd_cyc = -1, fd_with_go = 0;
   int acc_frame = 0, pop_frame = 0, frame_words = 0;
   int data_err = 0, viol = 0, exp_done = 0;
   bit go_prev = 1'b0, fd_prev = 1'b0;
   bit m_active = 1'b0;
   logic m_done_reg = 1'b1;
   int m_need = 0, m_rx = 0, m_delay = 0, m_rise_cyc = -1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      logic [31:0] w;
      @(negedge clk);
      case (src_mode)
         0:       s_valid = 1'b0;
         1:       s_valid = 1'b1;
         default: s_valid = ($urandom_range(0, 99) < 60);
      endcase
      s_data = next_data;
      case (full_mode)
         0:       wm_buffer_full = 1'b0;
         1:       wm_buffer_full = ($urandom_range(0, 99) < 30);
         2:       wm_buffer_full = (((cyc / 20) % 2) == 1);
         default: wm_buffer_full = 1'b1;
      endcase
      wm_done = m_done_reg;
      #1;
      if (wm_go) begin
         if (go_prev) viol++;
         go_cnt++;
         last_go_cyc = cyc;
         acc_frame   = 0;
         pop_frame   = 0;
         frame_words = int'(cfg_length >> 2);
         m_active    = 1'b1;
         m_need      = frame_words;
         m_rx        = 0;
         m_done_reg  = 1'b0;
         m_delay     = $urandom_range(0, 3);
      end
      if (s_valid && s_ready) begin
         if (acc_frame >= frame_words) viol++;
         if ((acc_frame - pop_frame) >= FIFO_DEPTH) viol++;
         exp_q.push_back(s_data);
         acc_frame++;
         next_data++;
      end
      if (wm_write_buffer) begin
         if (wm_buffer_full) viol++;
         if (pop_frame >= frame_words) viol++;
         if (exp_q.size() == 0) data_err++;
         else begin
            w = exp_q.pop_front();
            if (w !== wm_buffer_data) data_err++;
         end
         if (pop_frame == 0) first_w = wm_buffer_data;
         last_w = wm_buffer_data;
         pop_frame++;
         if (m_active) m_rx++;
      end
      if (frame_done) begin
         if (fd_prev) viol++;
         fd_cnt++;
         last_fd_cyc = cyc;
         if (wm_go) fd_with_go++;
      end
      go_prev = wm_go;
      fd_prev = frame_done;
      if (m_active && !wm_go && (m_rx >= m_need)) begin
         if (m_delay == 0) begin
            m_done_reg = 1'b1;
            m_active   = 1'b0;
            m_rise_cyc = cyc;
            exp_done++;
         end else m_delay--;
      end
      cyc++;
   endtask

   task automatic go_pulse(output int set_cyc);
      cfg_go  = 1'b1;
      set_cyc = cyc;
      tick();
      cfg_go  = 1'b0;
   endtask

   task automatic wait_frames(input string tag, input int n, input int budget);
      int start = fd_cnt;
      int k = 0;
      while ((fd_cnt < start + n) && (k < budget)) begin
         tick();
         k++;
      end
      check_eq({tag, "_frames"}, fd_cnt - start, n);
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_ctl"}, {status_busy, s_ready, wm_fixed_location, wm_go,
                               wm_write_buffer, frame_done, cfg_err}, 0);
      check_eq({tag, "_addr"}, {wm_write_base, wm_write_length}, 0);
      check_eq({tag, "_dat"}, {wm_buffer_data, frame_cnt}, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_quiet("rst");
      exp_q.delete();
      m_active = 1'b0; m_done_reg = 1'b1; exp_done = 0;
      go_prev = 1'b0; fd_prev = 1'b0; acc_frame = 0; pop_frame = 0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int sc, g0, b0, k;
      logic [15:0] fc0;
      logic [31:0] rb, rl;

      // Reset state
      tick();
      tick();
      check_quiet("init");
      rst_n = 1'b1;
      tick();

      // 1: single frame, 16 words carrying 0..15
      cfg_base = 32'h2000_0000; cfg_length = 32'd64; cfg_en = 2'b01;
      src_mode = 1; full_mode = 0; next_data = '0;
      g0 = go_cnt;
      go_pulse(sc);
      check_eq("t1_go_cyc", last_go_cyc, sc);
      tick();
      check_eq("t1_busy", status_busy, 1);
      wait_frames("t1", 1, 200);
      check_eq("t1_go_cnt", go_cnt - g0, 1);
      check_eq("t1_pops", pop_frame, 16);
      check_eq("t1_first", first_w, 0);
      check_eq("t1_last", last_w, 15);
      check_eq("t1_fd_after_done", last_fd_cyc, m_rise_cyc + 2);
      check_eq("t1_frame_cnt", frame_cnt, 1);
      check_eq("t1_base", wm_write_base, 32'h2000_0000);
      check_eq("t1_busy_end", status_busy, 0);
      check_eq("t1_data_err", data_err, 0);

      // 2: backpressure, write_user full held then toggled every 20 cycles
      full_mode = 3;
      go_pulse(sc);
      repeat (20) tick();
      check_eq("t2_sready", s_ready, 0);
      check_eq("t2_buffered", acc_frame - pop_frame, 16);
      full_mode = 2;
      wait_frames("t2", 1, 400);
      check_eq("t2_pops", pop_frame, 16);
      // 40-word frame: FIFO capacity, not frame length, limits acceptance
      cfg_length = 32'd160; full_mode = 3;
      go_pulse(sc);
      repeat (30) tick();
      check_eq("t2b_sready", s_ready, 0);
      check_eq("t2b_acc", acc_frame, FIFO_DEPTH);
      check_eq("t2b_pops", pop_frame, 0);
      full_mode = 1; src_mode = 2;
      wait_frames("t2b", 1, 1000);
      check_eq("t2b_pops_end", pop_frame, 40);
      check_eq("t2_data_err", data_err, 0);

      // 3: bad configurations, then a good one clears the flag
      g0 = go_cnt;
      cfg_length = 32'd6;
      go_pulse(sc); repeat (3) tick();
      check_eq("t3a_err", cfg_err, 1);
      check_eq("t3a_nogo", go_cnt - g0, 0);
      cfg_length = 32'd0;
      go_pulse(sc); repeat (3) tick();
      check_eq("t3b_err", cfg_err, 1);
      check_eq("t3b_busy", status_busy, 0);
      cfg_length = 32'd64; cfg_base = 32'h2000_0002;
      go_pulse(sc); repeat (3) tick();
      check_eq("t3c_err", cfg_err, 1);
      check_eq("t3c_nogo", go_cnt - g0, 0);
      cfg_base = 32'h2000_0000; cfg_en = 2'b00;
      go_pulse(sc); repeat (3) tick();
      check_eq("t3d_disabled_nogo", go_cnt - g0, 0);
      cfg_en = 2'b01;
      go_pulse(sc);
      check_eq("t3e_err_clear", cfg_err, 0);
      wait_frames("t3e", 1, 1000);
      check_eq("t3e_pops", pop_frame, 16);

      // 5: excess input after 8 of 8 words, and a go edge during XFER
      cfg_length = 32'd32; src_mode = 1; full_mode = 3;
      go_pulse(sc);
      repeat (12) tick();
      check_eq("t5_sready", s_ready, 0);
      check_eq("t5_acc", acc_frame, 8);
      g0 = go_cnt;
      cfg_base = 32'h3000_0000;
      go_pulse(sc); repeat (3) tick();
      check_eq("t5_go_ignored", go_cnt - g0, 0);
      check_eq("t5_base_held", wm_write_base, 32'h2000_0000);
      full_mode = 0;
      wait_frames("t5", 1, 200);
      check_eq("t5_pops", pop_frame, 8);
      cfg_base = 32'h2000_0000;

      // 6: reset mid-transfer after 5 pushes, then a clean frame
      cfg_length = 32'd256; src_mode = 2; full_mode = 0;
      go_pulse(sc);
      k = 0;
      while (pop_frame < 5 && k < 200) begin tick(); k++; end
      check_eq("t6_pre_pops", pop_frame, 5);
      do_reset();
      cfg_length = 32'd64;
      go_pulse(sc);
      check_eq("t6_go_cyc", last_go_cyc, sc);
      wait_frames("t6", 1, 1000);
      check_eq("t6_pops", pop_frame, 16);
      check_eq("t6_frame_cnt", frame_cnt, 1);
      check_eq("t6_data_err", data_err, 0);

      // 4: continuous mode, re-arm cleared during frame 3
      cfg_en = 2'b11; cfg_length = 32'd32; src_mode = 2; full_mode = 1;
      fc0 = frame_cnt; g0 = go_cnt; b0 = fd_with_go;
      go_pulse(sc);
      wait_frames("t4a", 2, 1000);
      check_eq("t4_back2back", fd_with_go - b0, 2);
      k = 0;
      while ((go_cnt - g0) < 3 && k < 50) begin tick(); k++; end
      tick(); tick();
      cfg_en = 2'b01;
      wait_frames("t4b", 1, 1000);
      repeat (10) tick();
      check_eq("t4_launches", go_cnt - g0, 3);
      check_eq("t4_frames", frame_cnt - fc0, 3);
      check_eq("t4_idle", status_busy, 0);
      check_eq("t4_frame_cnt_model", frame_cnt, exp_done);

      // Randomized frames: length, base, source and sink stalls
      for (int i = 0; i < 6; i++) begin
         rl = 32'(4 * $urandom_range(1, 40));
         rb = $urandom & 32'hFFFF_FFFC;
         cfg_length = rl; cfg_base = rb; cfg_en = 2'b01;
         src_mode = 2; full_mode = 1;
         go_pulse(sc);
         check_eq("rnd_go_cyc", last_go_cyc, sc);
         wait_frames("rnd", 1, 2000);
         check_eq("rnd_pops", pop_frame, rl >> 2);
         check_eq("rnd_len", wm_write_length, rl);
         check_eq("rnd_base", wm_write_base, rb);
      end
      check_eq("rnd_frame_cnt", frame_cnt, exp_done);
      check_eq("data_err", data_err, 0);
      check_eq("protocol_viol", viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
